booth_mul_ctrl: RTL and testbench

//  Sequential radix-4 (bit-pair) Booth multiply controller for the CPU's MUL instruction.

---
 rtl/booth_mul_ctrl.sv | 115 +++++++++++
 tb/tb_booth_mul_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mul_ctrl.sv
// Sequential radix-4 Booth multiply controller.
// Latches two signed operands on start, retires one multiplier bit-pair per clock
// and presents the full-width signed product on hi/lo with a busy/done handshake.
module booth_mul_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int STEPS = WIDTH / 2;
    localparam int CW    = $clog2(STEPS) + 1;

    typedef enum logic [1:0] {
        st_idle,
        st_run,
        st_done
    } state_t;

    state_t             state_q;
    // Accumulator and multiplicand copy carry 2 guard bits so -2M is always exact.
    logic [WIDTH+1:0]   a_q;
    logic [WIDTH+1:0]   mr_q;
    logic [WIDTH-1:0]   qr_q;
    logic               q1_q;
    logic [CW-1:0]      count_q;

    logic [2:0]         group;
    logic [WIDTH+1:0]   mr_x2;
    logic [WIDTH+1:0]   addend;
    logic [WIDTH+1:0]   sum;
    logic [WIDTH+1:0]   a_next;
    logic [WIDTH-1:0]   qr_next;
    logic               q1_next;
    logic               last_step;

    // Booth recode of the current bit-pair, add, then arithmetic shift right by 2.
    always_comb begin
        group  = {qr_q[1:0], q1_q};
        mr_x2  = {mr_q[WIDTH:0], 1'b0};
        addend = '0;
        case (group)
            3'b001, 3'b010: addend = mr_q;
            3'b011:         addend = mr_x2;
            3'b100:         addend = '0 - mr_x2;
            3'b101, 3'b110: addend = '0 - mr_q;
            default:        addend = '0;
        endcase
        sum       = a_q + addend;
        a_next    = {{2{sum[WIDTH+1]}}, sum[WIDTH+1:2]};
        qr_next   = {sum[1:0], qr_q[WIDTH-1:2]};
        q1_next   = qr_q[1];
        last_step = (count_q == CW'(STEPS - 1));
    end

    // Control FSM and datapath registers; clear dominates every other input.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_q <= st_idle;
            a_q     <= '0;
            mr_q    <= '0;
            qr_q    <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (state_q)
                st_idle: begin
                    if (start) begin
                        state_q <= st_run;
                        a_q     <= '0;
                        qr_q    <= multiplier;
                        q1_q    <= 1'b0;
                        mr_q    <= {{2{multiplicand[WIDTH-1]}}, multiplicand};
                        count_q <= '0;
                        busy    <= 1'b1;
                    end
                end
                st_run: begin
                    a_q     <= a_next;
                    qr_q    <= qr_next;
                    q1_q    <= q1_next;
                    count_q <= count_q + 1'b1;
                    if (last_step) begin
                        state_q <= st_done;
                        done    <= 1'b1;
                        hi      <= a_next[WIDTH-1:0];
                        lo      <= qr_next;
                    end
                end
                st_done: begin
                    state_q <= st_idle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    state_q <= st_idle;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_ctrl.sv
// Self-checking bench for booth_mul_ctrl: directed corner cases plus random operands,
// checked against a plain signed-multiply reference.
module tb_booth_mul_ctrl;

    localparam int WIDTH  = 32;
    localparam int LAT    = WIDTH / 2 + 1;
    localparam int PERIOD = WIDTH / 2 + 2;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic [31:0] multiplicand;
    logic [31:0] multiplier;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          tests = 0;
    int          fails = 0;
    logic [63:0] last_prod;

    booth_mul_ctrl #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .hi           (hi),
        .lo           (lo)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_prod(input logic [31:0] m, input logic [31:0] q);
        logic signed [63:0] ms;
        logic signed [63:0] qs;
        ms = $signed(m);
        qs = $signed(q);
        return ms * qs;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // n0 = cycles already elapsed since the accepting edge; returns cycle count when done seen.
    task automatic wait_done(input int n0, output int n);
        n = n0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic run_mul(input string tag, input logic [31:0] m, input logic [31:0] q);
        int          n;
        logic [63:0] exp;
        exp          = ref_prod(m, q);
        start        = 1'b1;
        multiplicand = m;
        multiplier   = q;
        tick();
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_hold"}, {hi, lo}, last_prod);
        wait_done(1, n);
        check({tag, "_lat"}, 64'(n), 64'(LAT));
        check({tag, "_prod"}, {hi, lo}, exp);
        check({tag, "_busydone"}, 64'(busy), 64'd1);
        tick();
        check({tag, "_end"}, 64'({busy, done}), 64'd0);
        last_prod = exp;
    endtask

    initial begin
        int          n;
        int          extra;
        int          k;
        int          cyc;
        int          last_done;
        int          stable_err;
        int          width_err;
        logic        prev_done;
        logic [63:0] cur;
        logic [31:0] ops_m [4];
        logic [31:0] ops_q [4];

        clear        = 1'b1;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        tick();
        tick();
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", 64'({busy, done}), 64'd0);
        clear     = 1'b0;
        last_prod = '0;
        tick();

        // Directed values
        run_mul("t1", 32'd3, 32'd4);
        run_mul("t2a", -32'sd7, 32'd5);
        run_mul("t2b", 32'd5, -32'sd7);
        run_mul("t3a", 32'h8000_0000, 32'h8000_0000);
        run_mul("t3b", 32'h7FFF_FFFF, 32'h7FFF_FFFF);
        run_mul("t3c", 32'h8000_0000, 32'h7FFF_FFFF);

        // Random operands, with corner values mixed in
        for (int i = 0; i < 12; i++) begin
            logic [31:0] m;
            logic [31:0] q;
            m = $urandom;
            q = $urandom;
            if (i % 4 == 1) m = 32'h8000_0000;
            if (i % 4 == 2) q = 32'hFFFF_FFFF;
            if (i % 4 == 3) m = {16'd0, m[15:0]};
            run_mul("rnd", m, q);
        end

        // T4: start during RUN is ignored and not queued
        start        = 1'b1;
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        tick();
        start = 1'b0;
        repeat (4) tick();
        start        = 1'b1;
        multiplicand = 32'd9;
        multiplier   = 32'd9;
        tick();
        start = 1'b0;
        wait_done(6, n);
        check("t4_lat", 64'(n), 64'(LAT));
        check("t4_prod", {hi, lo}, 64'd6);
        extra = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) extra++;
        end
        check("t4_nodup", 64'(extra), 64'd0);
        check("t4_idle", 64'(busy), 64'd0);

        // T5: clear mid-RUN (with start also high) aborts and zeroes hi/lo
        start        = 1'b1;
        multiplicand = 32'h1234;
        multiplier   = 32'h10;
        tick();
        start = 1'b0;
        repeat (7) tick();
        clear = 1'b1;
        start = 1'b1;
        tick();
        clear = 1'b0;
        start = 1'b0;
        check("t5_flags", 64'({busy, done}), 64'd0);
        check("t5_hilo", {hi, lo}, 64'd0);
        extra = 0;
        repeat (25) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        check("t5_nodone", 64'(extra), 64'd0);
        last_prod = '0;
        run_mul("t5b", 32'd6, 32'd7);

        // start together with clear in IDLE: request dropped
        clear        = 1'b1;
        start        = 1'b1;
        multiplicand = 32'd5;
        multiplier   = 32'd5;
        tick();
        clear = 1'b0;
        start = 1'b0;
        tick();
        check("clrstart_busy", 64'(busy), 64'd0);
        check("clrstart_hilo", {hi, lo}, 64'd0);
        last_prod = '0;

        // T6: start held high, back-to-back products
        ops_m[0] = 32'd11;          ops_q[0] = -32'sd13;
        ops_m[1] = $urandom;        ops_q[1] = $urandom;
        ops_m[2] = 32'h8000_0000;   ops_q[2] = 32'd3;
        ops_m[3] = $urandom;        ops_q[3] = 32'hFFFF_FFFF;
        start      = 1'b1;
        k          = 0;
        cyc        = 0;
        last_done  = 0;
        stable_err = 0;
        width_err  = 0;
        prev_done  = 1'b0;
        cur        = last_prod;
        while (k < 4 && cyc < 200) begin
            if (busy === 1'b0) begin
                multiplicand = ops_m[k];
                multiplier   = ops_q[k];
            end else begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            tick();
            cyc++;
            if (done === 1'b1) begin
                if (prev_done) width_err++;
                cur = ref_prod(ops_m[k], ops_q[k]);
                check("t6_prod", {hi, lo}, cur);
                if (k > 0) check("t6_gap", 64'(cyc - last_done), 64'(PERIOD));
                last_done = cyc;
                k++;
            end else if ({hi, lo} !== cur) begin
                stable_err++;
            end
            prev_done = done;
        end
        start = 1'b0;
        tick();
        if (done === 1'b1) width_err++;
        check("t6_count", 64'(k), 64'd4);
        check("t6_stable", 64'(stable_err), 64'd0);
        check("t6_width", 64'(width_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
